bid_memory_ctrl: RTL

- Parametrised successor to the team's bidirectional-bus bank memory.
- Holds NUM_BANKS registers of D_WID bits, addressed in binary rather than one-hot.
- Shares a single tri-state data bus with the host through a cycle-accurate state machine: write ack, registered read drive, mandatory bus-turnaround cycle.
- Flags illegal requests (out-of-range address, simultaneous wr and rd).
- Sits between a host bus master and the datapath configuration registers.

---
 rtl/bid_memory_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/bid_memory_ctrl.sv
// Banked register memory sharing one tri-state data bus with a host master.
// Legal accesses pulse ack; illegal ones pulse err; reads insert a bus-turnaround cycle.
module bid_memory_ctrl #(
    parameter int unsigned        D_WID     = 8,
    parameter int unsigned        NUM_BANKS = 5,
    parameter int unsigned        A_WID     = 3,
    parameter logic [D_WID-1:0]   RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [A_WID-1:0] addr,
    input  logic             wr,
    input  logic             rd,
    inout  wire  [D_WID-1:0] data,
    output logic             ack,
    output logic             err,
    output logic             busy,
    output logic             data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ACK   = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_TURN     = 3'd3,
        ST_ERR      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [D_WID-1:0]   bank_q [NUM_BANKS];
    logic [D_WID-1:0]   bank_d [NUM_BANKS];
    logic [D_WID-1:0]   rd_q, rd_d;
    logic [31:0]        addr_ext;
    logic               addr_ok;

    assign addr_ext = 32'(addr);
    assign addr_ok  = (addr_ext < 32'(NUM_BANKS));

    // The bus is released whenever we are not in RD_DRIVE, including during reset.
    assign data = data_oe ? rd_q : {D_WID{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                bank_q[i] <= RST_VAL;
            end
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            bank_d[i] = bank_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (wr && rd) begin
                    state_d = ST_ERR;
                end else if ((wr || rd) && !addr_ok) begin
                    state_d = ST_ERR;
                end else if (wr) begin
                    for (int i = 0; i < int'(NUM_BANKS); i++) begin
                        if (addr_ext == 32'(i)) bank_d[i] = data;
                    end
                    state_d = ST_WR_ACK;
                end else if (rd) begin
                    for (int i = 0; i < int'(NUM_BANKS); i++) begin
                        if (addr_ext == 32'(i)) rd_d = bank_q[i];
                    end
                    state_d = ST_RD_DRIVE;
                end
            end
            ST_WR_ACK:   state_d = ST_IDLE;
            ST_RD_DRIVE: state_d = ST_TURN;
            ST_TURN:     state_d = ST_IDLE;
            ST_ERR:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack     = 1'b0;
        err     = 1'b0;
        data_oe = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_WR_ACK:   ack = 1'b1;
            ST_RD_DRIVE: begin
                ack     = 1'b1;
                data_oe = 1'b1;
            end
            ST_ERR:      err = 1'b1;
            default:     ;
        endcase
    end

endmodule
